uart_tx_prescaled: RTL and testbench

UART transmitter, the TX counterpart of the receive path's edge/bit counting.
- Runs on the same oversampled clock as the receiver.
- Serializes one 8-bit word per frame: start bit, 8 data bits LSB first, optional parity, one stop bit.
- Each bit is held for PRESCALE clock cycles using internal edge and bit counters, so TX and RX share one clock and one PRESCALE setting.

---
 rtl/uart_tx_prescaled.sv | 150 +++++++++++++++
 tb/tb_uart_tx_prescaled.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_prescaled.sv
// uart_tx_prescaled -- UART transmitter that runs on the receiver's oversampled
// clock. Each frame carries a start bit (0), DATA_WIDTH data bits sent LSB
// first, an optional parity bit and one stop bit (1). Every bit is held for
// PRESCALE clock cycles, counted by an internal edge counter.
//
// Ports:
//   CLK         system clock, all logic on the rising edge
//   RST         synchronous active-low reset
//   P_DATA      parallel word to send, latched on acceptance
//   DATA_VALID  request strobe, accepted only while Busy=0
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   PRESCALE    clock cycles per bit (0 behaves as 1)
//   TX_OUT      registered serial line, idle high
//   Busy        registered, high from acceptance through the last stop cycle
module uart_tx_prescaled #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_WIDTH-1:0] ONE      = 1;
  localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q,    state_n;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_n;
  logic [BW-1:0]             bit_cnt_q,  bit_cnt_n;
  logic [DATA_WIDTH-1:0]     shift_q,    shift_n;
  logic [PRESCALE_WIDTH-1:0] presc_q,    presc_n;
  logic                      par_en_q,   par_en_n;
  logic                      par_bit_q,  par_bit_n;
  logic                      tx_q,       tx_n;
  logic                      busy_q,     busy_n;
  logic                      bit_done;

  // Last cycle of the current bit period.
  assign bit_done = ((edge_cnt_q + ONE) == presc_q);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state_q;
    edge_cnt_n = edge_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    presc_n    = presc_q;
    par_en_n   = par_en_q;
    par_bit_n  = par_bit_q;
    tx_n       = tx_q;
    busy_n     = busy_q;

    if (state_q == IDLE) begin
      tx_n       = 1'b1;
      busy_n     = 1'b0;
      edge_cnt_n = '0;
      bit_cnt_n  = '0;
      if (DATA_VALID) begin
        // Latch the whole frame configuration; later input changes are ignored.
        state_n   = START;
        tx_n      = 1'b0;
        busy_n    = 1'b1;
        shift_n   = P_DATA;
        par_en_n  = PAR_EN;
        // Parity is fixed at acceptance because the data bits get shifted out.
        par_bit_n = (^P_DATA) ^ PAR_TYP;
        presc_n   = (PRESCALE == '0) ? ONE : PRESCALE;
      end
    end else begin
      edge_cnt_n = bit_done ? '0 : edge_cnt_q + ONE;
      if (bit_done) begin
        // tx_n carries the value of the bit being entered, so TX_OUT changes
        // on the same edge as the state.
        case (state_q)
          START: begin
            state_n = DATA;
            tx_n    = shift_q[0];
          end
          DATA: begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_n = '0;
              state_n   = par_en_q ? PARITY : STOP;
              tx_n      = par_en_q ? par_bit_q : 1'b1;
            end else begin
              bit_cnt_n = bit_cnt_q + 1'b1;
              shift_n   = shift_q >> 1;
              tx_n      = shift_q[1];
            end
          end
          PARITY: begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
          STOP: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end
          default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            busy_n  = 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: the data shift register is reset along with the control state so
      // an aborted frame leaves no stale payload behind.
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      presc_q    <= ONE;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      edge_cnt_q <= edge_cnt_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      presc_q    <= presc_n;
      par_en_q   <= par_en_n;
      par_bit_q  <= par_bit_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// tb_uart_tx_prescaled -- directed and randomized frames checked cycle by cycle
// against a per-cycle line waveform built from the frame format rules.
module tb_uart_tx_prescaled;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       TX_OUT;
  logic       Busy;

  int total;
  int bad;

  uart_tx_prescaled #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle. Requests a frame that is accepted on
  // the next rising edge, then checks TX_OUT and Busy on every cycle of it and
  // on the idle cycle that follows. With hold=1 DATA_VALID stays high so the
  // next frame is accepted right after that idle cycle. At cycle 'disturb' the
  // inputs are scrambled and DATA_VALID pulsed; the frame must not notice.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input bit hold, input int disturb);
    bit exp_bits[$];
    int p;
    int len;
    p = (ps == 0) ? 1 : int'(ps);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    // Even parity makes the total count of ones even; odd makes it odd.
    if (pe) exp_bits.push_back(bit'(($countones(d) % 2) != 0) ^ pt);
    exp_bits.push_back(1'b1);
    len = exp_bits.size() * p;

    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps; DATA_VALID = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge CLK);
      check($sformatf("tx d=%02h p=%0d c=%0d", d, p, c), TX_OUT, exp_bits[c / p]);
      check($sformatf("busy d=%02h c=%0d", d, c), Busy, 1'b1);
      if (!hold) DATA_VALID = 1'b0;
      if (c == disturb) begin
        P_DATA = ~d; PRESCALE = 6'd4; PAR_EN = ~pe; PAR_TYP = ~pt; DATA_VALID = 1'b1;
      end else if (c == disturb + 1 && !hold) begin
        DATA_VALID = 1'b0;
      end
    end
    @(negedge CLK);
    check($sformatf("idle_tx d=%02h", d), TX_OUT, 1'b1);
    check($sformatf("idle_busy d=%02h", d), Busy, 1'b0);
    if (!hold) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        check("post_idle_tx", TX_OUT, 1'b1);
        check("post_idle_busy", Busy, 1'b0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b0;
    PAR_TYP = 1'b0; PRESCALE = 6'd8;

    // Reset held with a pending request: line stays idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rst_tx", TX_OUT, 1'b1);
      check("rst_busy", Busy, 1'b0);
    end
    DATA_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("after_rst_tx", TX_OUT, 1'b1);
    check("after_rst_busy", Busy, 1'b0);

    // Basic frame, no parity.
    run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, -10);
    // Parity, even then odd.
    run_frame(8'h07, 1'b1, 1'b0, 6'd4, 1'b0, -10);
    run_frame(8'h07, 1'b1, 1'b1, 6'd4, 1'b0, -10);
    // Inputs changed and DATA_VALID pulsed mid-frame.
    run_frame(8'h3C, 1'b0, 1'b0, 6'd16, 1'b0, 20);
    // PRESCALE=0 behaves as 1, and the largest setting.
    run_frame(8'h96, 1'b1, 1'b1, 6'd0, 1'b0, -10);
    run_frame(8'h01, 1'b0, 1'b0, 6'd63, 1'b0, -10);

    // Back-to-back frames with DATA_VALID held high.
    run_frame(8'h5A, 1'b0, 1'b0, 6'd4, 1'b1, -10);
    run_frame(8'hC3, 1'b0, 1'b0, 6'd4, 1'b1, -10);
    run_frame(8'hFF, 1'b0, 1'b0, 6'd4, 1'b1, -10);
    DATA_VALID = 1'b0;
    @(negedge CLK);
    check("b2b_end_busy", Busy, 1'b0);

    // Reset during data bit 3 (bit periods: start, d0, d1, d2, d3 -> cycles 16..19).
    P_DATA = 8'hF0; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd4; DATA_VALID = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end
    check("pre_abort_busy", Busy, 1'b1);
    check("pre_abort_tx_d3", TX_OUT, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_tx", TX_OUT, 1'b1);
    check("abort_busy", Busy, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    check("post_abort_tx", TX_OUT, 1'b1);
    check("post_abort_busy", Busy, 1'b0);
    run_frame(8'h6B, 1'b1, 1'b0, 6'd4, 1'b0, -10);

    // Randomized frames.
    for (int n = 0; n < 8; n++) begin
      logic [7:0] rd;
      logic       rpe;
      logic       rpt;
      logic [5:0] rps;
      rd  = 8'($urandom);
      rpe = 1'($urandom);
      rpt = 1'($urandom);
      rps = 6'($urandom_range(0, 12));
      run_frame(rd, rpe, rpt, rps, 1'b0, int'($urandom_range(0, 8)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
